// File: rtl/layer_scroll_ctrl_if.sv
// Configuration port of layer_scroll_ctrl: valid/ready write of one layer's
// velocity and, optionally, its position.
// master: game logic side, slave: the scroll controller.
interface layer_scroll_ctrl_if #(
  parameter int NUM_LAYERS = 4,
  parameter int HWIDTH     = 12,
  parameter int VWIDTH     = 12,
  parameter int VELW       = 6
);
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [LW-1:0]     cfg_layer;
  logic              cfg_load_pos;
  logic [HWIDTH-1:0] cfg_pos_h;
  logic [VWIDTH-1:0] cfg_pos_v;
  logic [VELW-1:0]   cfg_vel_h;
  logic [VELW-1:0]   cfg_vel_v;

  modport master (
    output cfg_valid, cfg_layer, cfg_load_pos, cfg_pos_h, cfg_pos_v,
           cfg_vel_h, cfg_vel_v,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_layer, cfg_load_pos, cfg_pos_h, cfg_pos_v,
           cfg_vel_h, cfg_vel_v,
    output cfg_ready
  );
endinterface

// File: rtl/layer_scroll_ctrl.sv
// layer_scroll_ctrl: per-frame scroll scheduler for the stacked layer pipeline.
// Each frame_start walks all layers (pos += vel, wrapped into [0, RANGE-1])
// and then commits every offset in one cycle, so outputs never tear mid-frame.
// Optional build macro SCROLL_PAUSE_EN adds input `pause`: a paused frame
// skips the walk, holds positions, and still commits and counts the frame.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  S_IDLE   | waiting for frame_start; config port open
//  S_WALK   | one layer read per cycle, wrapped result written back next cycle
//  S_COMMIT | copy working positions to outputs, bump frame_count
//
// The walk is split into a read/compute stage and a write-back stage so the
// adder/wrap logic does not sit between the array read mux and array write.
// Frame latency is therefore NUM_LAYERS+2 edges from the sampling edge.
module layer_scroll_ctrl #(
  parameter int NUM_LAYERS = 4,
  parameter int HWIDTH     = 12,
  parameter int VWIDTH     = 12,
  parameter int VELW       = 6,
  parameter int HRANGE     = 640,
  parameter int VRANGE     = 480
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_start,
`ifdef SCROLL_PAUSE_EN
  input  logic                         pause,
`endif
  layer_scroll_ctrl_if.slave           cfg,
  output logic [NUM_LAYERS*HWIDTH-1:0] hoffset_flat,
  output logic [NUM_LAYERS*VWIDTH-1:0] voffset_flat,
  output logic                         busy,
  output logic                         overrun,
  output logic [15:0]                  frame_count
);

  localparam int LW   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int LAST = NUM_LAYERS - 1;

  localparam logic signed [HWIDTH:0] H_RANGE = (HWIDTH+1)'(HRANGE);
  localparam logic signed [VWIDTH:0] V_RANGE = (VWIDTH+1)'(VRANGE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WALK,
    S_COMMIT
  } state_t;

  state_t            state;

  logic [HWIDTH-1:0] pos_h [NUM_LAYERS];
  logic [VWIDTH-1:0] pos_v [NUM_LAYERS];
  logic [VELW-1:0]   vel_h [NUM_LAYERS];
  logic [VELW-1:0]   vel_v [NUM_LAYERS];

  logic [LW-1:0]     rd_idx;
  logic              rd_act;
  logic [LW-1:0]     wb_idx;
  logic              wb_vld;
  logic [HWIDTH-1:0] wb_h;
  logic [VWIDTH-1:0] wb_v;

  logic signed [HWIDTH:0] sum_h, wrap_h;
  logic signed [VWIDTH:0] sum_v, wrap_v;

  logic pause_req;
  logic cfg_hit;

`ifdef SCROLL_PAUSE_EN
  assign pause_req = pause;
`else
  assign pause_req = 1'b0;
`endif

  // Writes to layers beyond NUM_LAYERS-1 are handshaken but dropped.
  assign cfg_hit = cfg.cfg_valid && cfg.cfg_ready && (32'(cfg.cfg_layer) <= LAST);

  // Advance the layer under rd_idx by one frame; the velocity is small enough
  // that a single add or subtract of RANGE always lands back in range.
  always_comb begin
    sum_h  = $signed({pos_h[rd_idx][HWIDTH-1], pos_h[rd_idx]})
           + $signed({{(HWIDTH+1-VELW){vel_h[rd_idx][VELW-1]}}, vel_h[rd_idx]});
    sum_v  = $signed({pos_v[rd_idx][VWIDTH-1], pos_v[rd_idx]})
           + $signed({{(VWIDTH+1-VELW){vel_v[rd_idx][VELW-1]}}, vel_v[rd_idx]});
    wrap_h = sum_h;
    wrap_v = sum_v;
    if (sum_h >= H_RANGE)
      wrap_h = sum_h - H_RANGE;
    else if (sum_h < 0)
      wrap_h = sum_h + H_RANGE;
    if (sum_v >= V_RANGE)
      wrap_v = sum_v - V_RANGE;
    else if (sum_v < 0)
      wrap_v = sum_v + V_RANGE;
  end

  // Sequencer: config writes, layer walk, atomic commit and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rd_idx        <= '0;
      rd_act        <= 1'b0;
      wb_idx        <= '0;
      wb_vld        <= 1'b0;
      wb_h          <= '0;
      wb_v          <= '0;
      cfg.cfg_ready <= 1'b1;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      frame_count   <= '0;
      hoffset_flat  <= '0;
      voffset_flat  <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        pos_h[i] <= '0;
        pos_v[i] <= '0;
        vel_h[i] <= '0;
        vel_v[i] <= '0;
      end
    end else begin
      if (frame_start && (state != S_IDLE))
        overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (cfg_hit) begin
            vel_h[cfg.cfg_layer] <= cfg.cfg_vel_h;
            vel_v[cfg.cfg_layer] <= cfg.cfg_vel_v;
            if (cfg.cfg_load_pos) begin
              pos_h[cfg.cfg_layer] <= cfg.cfg_pos_h;
              pos_v[cfg.cfg_layer] <= cfg.cfg_pos_v;
            end
          end
          if (frame_start) begin
            cfg.cfg_ready <= 1'b0;
            busy          <= 1'b1;
            if (pause_req) begin
              state <= S_COMMIT;
            end else begin
              state  <= S_WALK;
              rd_idx <= '0;
              rd_act <= 1'b1;
            end
          end
        end

        S_WALK: begin
          if (rd_act) begin
            wb_h   <= wrap_h[HWIDTH-1:0];
            wb_v   <= wrap_v[VWIDTH-1:0];
            wb_idx <= rd_idx;
            wb_vld <= 1'b1;
            if (rd_idx == LW'(LAST))
              rd_act <= 1'b0;
            else
              rd_idx <= rd_idx + 1'b1;
          end else begin
            wb_vld <= 1'b0;
          end
          if (wb_vld) begin
            pos_h[wb_idx] <= wb_h;
            pos_v[wb_idx] <= wb_v;
            if (wb_idx == LW'(LAST))
              state <= S_COMMIT;
          end
        end

        S_COMMIT: begin
          for (int i = 0; i < NUM_LAYERS; i++) begin
            hoffset_flat[i*HWIDTH +: HWIDTH] <= pos_h[i];
            voffset_flat[i*VWIDTH +: VWIDTH] <= pos_v[i];
          end
          frame_count   <= frame_count + 16'd1;
          cfg.cfg_ready <= 1'b1;
          busy          <= 1'b0;
          state         <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_scroll_ctrl.sv
// Testbench for layer_scroll_ctrl: directed scenarios plus randomized
// config/frame traffic, compared against a modular-arithmetic layer model.
module tb_layer_scroll_ctrl;
  localparam int N    = 4;
  localparam int HW   = 12;
  localparam int VW   = 12;
  localparam int VELW = 6;
  localparam int HR   = 640;
  localparam int VR   = 480;
  localparam int LW   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
`ifdef SCROLL_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic [N*HW-1:0] hoffset_flat;
  logic [N*VW-1:0] voffset_flat;
  logic            busy;
  logic            overrun;
  logic [15:0]     frame_count;

  layer_scroll_ctrl_if #(.NUM_LAYERS(N), .HWIDTH(HW), .VWIDTH(VW), .VELW(VELW)) cfg_if ();

  layer_scroll_ctrl #(
    .NUM_LAYERS(N), .HWIDTH(HW), .VWIDTH(VW), .VELW(VELW), .HRANGE(HR), .VRANGE(VR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
`ifdef SCROLL_PAUSE_EN
    .pause        (pause),
`endif
    .cfg          (cfg_if.slave),
    .hoffset_flat (hoffset_flat),
    .voffset_flat (voffset_flat),
    .busy         (busy),
    .overrun      (overrun),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: working positions, velocities, committed offsets
  int m_ph [N];
  int m_pv [N];
  int m_vh [N];
  int m_vv [N];
  int m_ch [N];
  int m_cv [N];
  int m_fc;
  bit m_ovr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int wrap(input int p, input int v, input int r);
    int s;
    s = (p + v) % r;
    if (s < 0) s += r;
    return s;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_ph[i] = 0; m_pv[i] = 0; m_vh[i] = 0; m_vv[i] = 0; m_ch[i] = 0; m_cv[i] = 0;
    end
    m_fc  = 0;
    m_ovr = 0;
  endtask

  task automatic m_cfg(input int layer, input bit load, input int ph, input int pv,
                       input int vh, input int vv);
    if (layer < N) begin
      m_vh[layer] = vh;
      m_vv[layer] = vv;
      if (load) begin
        m_ph[layer] = ph;
        m_pv[layer] = pv;
      end
    end
  endtask

  task automatic m_walk();
    for (int i = 0; i < N; i++) begin
      m_ph[i] = wrap(m_ph[i], m_vh[i], HR);
      m_pv[i] = wrap(m_pv[i], m_vv[i], VR);
    end
  endtask

  task automatic m_commit();
    for (int i = 0; i < N; i++) begin
      m_ch[i] = m_ph[i];
      m_cv[i] = m_pv[i];
    end
    m_fc = (m_fc + 1) % 65536;
  endtask

  function automatic logic [N*HW-1:0] exp_h();
    logic [N*HW-1:0] r;
    for (int i = 0; i < N; i++) r[i*HW +: HW] = HW'(m_ch[i]);
    return r;
  endfunction

  function automatic logic [N*VW-1:0] exp_v();
    logic [N*VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*VW +: VW] = VW'(m_cv[i]);
    return r;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_hoff"}, 64'(hoffset_flat), 64'(exp_h()));
    chk({tag, "_voff"}, 64'(voffset_flat), 64'(exp_v()));
    chk({tag, "_fc"}, 64'(frame_count), 64'(m_fc));
    chk({tag, "_ovr"}, 64'(overrun), 64'(m_ovr));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rdy"}, 64'(cfg_if.cfg_ready), 64'd1);
  endtask

  task automatic drive_cfg(input int layer, input bit load, input int ph, input int pv,
                           input int vh, input int vv);
    cfg_if.cfg_valid    = 1'b1;
    cfg_if.cfg_layer    = LW'(layer);
    cfg_if.cfg_load_pos = load;
    cfg_if.cfg_pos_h    = HW'(ph);
    cfg_if.cfg_pos_v    = VW'(pv);
    cfg_if.cfg_vel_h    = VELW'(vh);
    cfg_if.cfg_vel_v    = VELW'(vv);
  endtask

  // Called at #1 after a posedge; holds valid until the handshake completes.
  task automatic cfg_write(input int layer, input bit load, input int ph, input int pv,
                           input int vh, input int vv, output int waits);
    bit done;
    done  = 0;
    waits = 0;
    drive_cfg(layer, load, ph, pv, vh, vv);
    while (!done && waits <= 100) begin
      @(negedge clk);
      if (cfg_if.cfg_ready) done = 1;
      else waits++;
    end
    if (!done) begin
      chk("cfg_timeout", 64'd0, 64'd1);
      cfg_if.cfg_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      cfg_if.cfg_valid = 1'b0;
      m_cfg(layer, load, ph, pv, vh, vv);
    end
  endtask

  // Pulse frame_start from IDLE; returns #1 after the sampling edge.
  task automatic start_frame(input bit with_cfg, input int layer, input bit load,
                             input int ph, input int pv, input int vh, input int vv);
    frame_start = 1'b1;
    if (with_cfg) drive_cfg(layer, load, ph, pv, vh, vv);
    @(posedge clk);
    #1;
    frame_start      = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    if (with_cfg) m_cfg(layer, load, ph, pv, vh, vv);
    m_walk();
  endtask

  task automatic run_frame(input string tag, input bit with_cfg, input int layer,
                           input bit load, input int ph, input int pv, input int vh,
                           input int vv);
    start_frame(with_cfg, layer, load, ph, pv, vh, vv);
    chk({tag, "_busy1"}, 64'(busy), 64'd1);
    chk({tag, "_rdy0"}, 64'(cfg_if.cfg_ready), 64'd0);
    repeat (N + 1) @(posedge clk);
    #1;
    chk({tag, "_hold"}, 64'(hoffset_flat), 64'(exp_h()));
    @(posedge clk);
    #1;
    m_commit();
    check_idle(tag);
  endtask

  int w;
  int nw;

  initial begin
    cfg_if.cfg_valid    = 1'b0;
    cfg_if.cfg_layer    = '0;
    cfg_if.cfg_load_pos = 1'b0;
    cfg_if.cfg_pos_h    = '0;
    cfg_if.cfg_pos_v    = '0;
    cfg_if.cfg_vel_h    = '0;
    cfg_if.cfg_vel_v    = '0;
    m_reset();

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame("zero", 0, 0, 0, 0, 0, 0, 0);

    cfg_write(1, 1, 630, 0, 15, 0, w);
    run_frame("l1wrap", 0, 0, 0, 0, 0, 0, 0);
    chk("l1_hoff", 64'(hoffset_flat[HW +: HW]), 64'd5);

    cfg_write(2, 1, 0, 3, 0, -8, w);
    run_frame("l2a", 0, 0, 0, 0, 0, 0, 0);
    chk("l2_voff_a", 64'(voffset_flat[2*VW +: VW]), 64'd475);
    run_frame("l2b", 0, 0, 0, 0, 0, 0, 0);
    chk("l2_voff_b", 64'(voffset_flat[2*VW +: VW]), 64'd467);

    // config held through a walk: lands once, after the commit
    start_frame(0, 0, 0, 0, 0, 0, 0);
    m_commit();
    cfg_write(3, 0, 0, 0, -5, 7, w);
    chk("stall_cycles", 64'(w), 64'(N + 2));
    check_idle("stall");
    run_frame("after_stall", 0, 0, 0, 0, 0, 0, 0);

    // config coincident with frame_start is used by that frame
    run_frame("coinc", 1, 0, 1, 0, 0, 2, 0);
    chk("coinc_h0", 64'(hoffset_flat[HW-1:0]), 64'd2);

    // second frame_start during the walk: ignored but sticky overrun
    start_frame(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    m_commit();
    m_ovr = 1;
    check_idle("ovr");
    repeat (5) @(posedge clk);
    #1;
    check_idle("ovr_hold");

    for (int it = 0; it < 30; it++) begin
      nw = $urandom_range(0, 2);
      for (int k = 0; k < nw; k++)
        cfg_write($urandom_range(0, N - 1), 1'($urandom_range(0, 1)),
                  $urandom_range(0, HR - 1), $urandom_range(0, VR - 1),
                  $urandom_range(0, 63) - 32, $urandom_range(0, 63) - 32, w);
      if ($urandom_range(0, 3) == 0)
        run_frame("rnd", 1, $urandom_range(0, N - 1), 1'($urandom_range(0, 1)),
                  $urandom_range(0, HR - 1), $urandom_range(0, VR - 1),
                  $urandom_range(0, 63) - 32, $urandom_range(0, 63) - 32);
      else
        run_frame("rnd", 0, 0, 0, 0, 0, 0, 0);
    end

`ifdef SCROLL_PAUSE_EN
    pause = 1'b1;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    @(posedge clk);
    #1;
    pause = 1'b0;
    m_fc = (m_fc + 1) % 65536;
    check_idle("pause");
`endif

    // reset in the middle of a walk
    start_frame(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_idle("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame("post_rst", 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
